// File: rtl/mem_access_sequencer_pkg.sv
// Shared types and defaults for the memory access sequencer.
// Imported by the interface, the sequencer top and its timeout counter.
package mem_access_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic FETCH = 1'b0;
    localparam logic DATA  = 1'b1;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/mem_access_sequencer_if.sv
// CPU-side strobes and memory bus of the sequencer in one bundle.
// master = sequencer, slave = control FSM plus memory.
interface mem_access_sequencer_if
    import mem_access_sequencer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              cpu_read;
    logic              cpu_write;
    logic              cpu_iord;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              stall;
    logic              ir_load;
    logic              mdr_load;
    logic [DATA_W-1:0] rdata_q;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              bus_error;

    modport master (
        input  cpu_read, cpu_write, cpu_iord,
        input  cpu_addr, cpu_wdata,
        input  mem_ack, mem_rdata,
        output stall, ir_load, mdr_load, rdata_q,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output bus_error
    );

    modport slave (
        output cpu_read, cpu_write, cpu_iord,
        output cpu_addr, cpu_wdata,
        output mem_ack, mem_rdata,
        input  stall, ir_load, mdr_load, rdata_q,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  bus_error
    );

endinterface

// File: rtl/mem_timeout_counter.sv
// Counts BUSY cycles; expired flags the last allowed cycle.
module mem_timeout_counter
    import mem_access_sequencer_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en & (cnt_q == LAST);

endmodule

// File: rtl/mem_access_sequencer.sv
// Turns level-held mem_read/mem_write strobes into single req/ack
// transactions, stalling the control FSM and pulsing IR/MDR loads.
module mem_access_sequencer
    import mem_access_sequencer_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   reset,
    mem_access_sequencer_if.master bus
);

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              iord_q, iord_d;
    logic              abort_q, abort_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              cpu_req;
    logic              expired;
    logic              done;

    assign cpu_req = bus.cpu_read | bus.cpu_write;

    mem_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_tmo (
        .clk    (clk),
        .reset  (reset),
        .clr    (state_q != BUSY),
        .en     (state_q == BUSY),
        .expired(expired)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        iord_d  = iord_q;
        abort_d = abort_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = bus.cpu_write;
                    addr_d  = bus.cpu_addr;
                    wdata_d = bus.cpu_wdata;
                    iord_d  = bus.cpu_iord;
                    abort_d = 1'b0;
                    // read+write together is executed as a write
                    if (bus.cpu_read & bus.cpu_write) begin
                        err_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (bus.mem_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                end else if (expired) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    abort_d = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            iord_q  <= FETCH;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            iord_q  <= iord_d;
            abort_q <= abort_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign done = (state_q == DONE) & ~we_q & ~abort_q;

    assign bus.stall     = ((state_q == IDLE) & cpu_req)
                         | (state_q == BUSY);
    assign bus.ir_load   = done & (iord_q == FETCH);
    assign bus.mdr_load  = done & (iord_q == DATA);
    assign bus.rdata_q   = rdata_q;
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.bus_error = err_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Table-driven bench for mem_access_sequencer with TIMEOUT=8.
module tb_mem_access_sequencer;

    localparam int TMO = 8;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        iord;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_at;
        logic [31:0] rdata;
        int          req_n;
        logic        we;
        logic        ir;
        logic        mdr;
        logic        err;
        logic [31:0] exp_rdata;
    } vec_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    vec_t vecs [10];
    vec_t exp_q [$];

    mem_access_sequencer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_access_sequencer #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic rd, input logic wr, input logic iord,
        input logic [31:0] addr, input logic [31:0] wdata,
        input int ack_at, input logic [31:0] rdata, input int req_n,
        input logic we, input logic ir, input logic mdr, input logic err,
        input logic [31:0] exp_rdata);
        vec_t v;
        v.rd = rd; v.wr = wr; v.iord = iord;
        v.addr = addr; v.wdata = wdata;
        v.ack_at = ack_at; v.rdata = rdata; v.req_n = req_n;
        v.we = we; v.ir = ir; v.mdr = mdr; v.err = err;
        v.exp_rdata = exp_rdata;
        return v;
    endfunction

    // Entered and left at a negedge with the DUT in IDLE.
    task automatic run_vec(input vec_t v);
        vec_t e;
        int   n;
        exp_q.push_back(v);
        bus.cpu_read  = v.rd;
        bus.cpu_write = v.wr;
        bus.cpu_iord  = v.iord;
        bus.cpu_addr  = v.addr;
        bus.cpu_wdata = v.wdata;
        #1;
        chk("stall_idle", 32'(bus.stall), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        bus.cpu_iord  = ~v.iord;
        bus.cpu_addr  = $urandom;
        bus.cpu_wdata = $urandom;
        n = 0;
        while (bus.mem_req && n < 200) begin
            n++;
            chk("busy_addr", bus.mem_addr, v.addr);
            chk("busy_we", 32'(bus.mem_we), 32'(v.we));
            if (v.we) chk("busy_wdata", bus.mem_wdata, v.wdata);
            chk("busy_stall", 32'(bus.stall), 32'd1);
            chk("busy_loads", 32'(bus.ir_load | bus.mdr_load), 32'd0);
            if (n == v.ack_at) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = v.rdata;
            end
            @(posedge clk);
            @(negedge clk);
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 32'h0BAD0BAD;
        end
        e = exp_q.pop_front();
        chk("req_cycles", 32'(n), 32'(e.req_n));
        chk("done_req", 32'(bus.mem_req), 32'd0);
        chk("done_stall", 32'(bus.stall), 32'd0);
        chk("ir_load", 32'(bus.ir_load), 32'(e.ir));
        chk("mdr_load", 32'(bus.mdr_load), 32'(e.mdr));
        chk("bus_error", 32'(bus.bus_error), 32'(e.err));
        chk("rdata_q", bus.rdata_q, e.exp_rdata);
        @(posedge clk);
        @(negedge clk);
        chk("loads_after", 32'(bus.ir_load | bus.mdr_load), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        tests = 0;
        fails = 0;
        vecs[0] = mk(1, 0, 0, 32'h100, 0, 1, 32'h00500093, 1,
                     0, 1, 0, 0, 32'h00500093);
        vecs[1] = mk(1, 0, 1, 32'h2000, 0, 5, 32'hDEADBEEF, 5,
                     0, 0, 1, 0, 32'hDEADBEEF);
        vecs[2] = mk(0, 1, 1, 32'h40, 32'h12345678, 2, 32'hFFFF0000, 2,
                     1, 0, 0, 0, 32'hDEADBEEF);
        vecs[3] = mk(1, 0, 0, 32'h104, 0, 1, 32'h00A00113, 1,
                     0, 1, 0, 0, 32'h00A00113);
        vecs[4] = mk(1, 0, 0, 32'h108, 0, TMO, 32'h11111111, TMO,
                     0, 1, 0, 0, 32'h11111111);
        vecs[5] = mk(1, 0, 1, 32'h3000, 0, 3, 32'hCAFEF00D, 3,
                     0, 0, 1, 0, 32'hCAFEF00D);
        vecs[6] = mk(1, 0, 0, 32'h200, 0, 0, 32'h77777777, TMO,
                     0, 0, 0, 1, 32'hCAFEF00D);
        vecs[7] = mk(1, 0, 0, 32'h300, 0, 2, 32'h22222222, 2,
                     0, 1, 0, 1, 32'h22222222);
        vecs[8] = mk(1, 0, 0, 32'h500, 0, 4, 32'h33333333, 4,
                     0, 1, 0, 0, 32'h33333333);
        vecs[9] = mk(1, 1, 1, 32'h50, 32'hA5A5A5A5, 1, 32'h44444444, 1,
                     1, 0, 0, 1, 32'h33333333);

        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        bus.cpu_iord  = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        chk("rst_rdata", bus.rdata_q, 32'd0);
        chk("rst_err", 32'(bus.bus_error), 32'd0);
        chk("rst_loads", 32'(bus.ir_load | bus.mdr_load), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // stray ack while idle
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h99999999;
        @(posedge clk);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("stray_req", 32'(bus.mem_req), 32'd0);
        chk("stray_rdata", bus.rdata_q, 32'hCAFEF00D);
        chk("stray_stall", 32'(bus.stall), 32'd0);
        chk("stray_err", 32'(bus.bus_error), 32'd0);
        chk("stray_loads", 32'(bus.ir_load | bus.mdr_load), 32'd0);

        for (int i = 6; i < 8; i++) run_vec(vecs[i]);

        // async reset in the middle of a BUSY phase
        bus.cpu_read = 1'b1;
        bus.cpu_iord = 1'b0;
        bus.cpu_addr = 32'h400;
        @(posedge clk);
        @(negedge clk);
        bus.cpu_read = 1'b0;
        chk("mid_req_pre", 32'(bus.mem_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_req", 32'(bus.mem_req), 32'd0);
        chk("mid_stall", 32'(bus.stall), 32'd0);
        chk("mid_loads", 32'(bus.ir_load | bus.mdr_load), 32'd0);
        chk("mid_err", 32'(bus.bus_error), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_req", 32'(bus.mem_req), 32'd0);
        chk("post_stall", 32'(bus.stall), 32'd0);

        run_vec(vecs[8]);
        run_vec(vecs[9]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
